// File: rtl/memory_exerciser_pkg.sv
// memory_exerciser_pkg: state encoding shared by memory-bus initiators
package memory_exerciser_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/memory_exerciser_if.sv
// memory_exerciser_if: memory bus between an initiator (master) and a responder (slave)
interface memory_exerciser_if #(
  parameter int addr_size = 16,
  parameter int word_size = 16
);
  logic [addr_size-1:0] addr;
  logic [word_size-1:0] data_out;
  logic [word_size-1:0] data_in;
  logic                 write_en;
  modport master(output addr, data_out, write_en, input data_in);
  modport slave(input addr, data_out, write_en, output data_in);
endinterface

// File: rtl/memory_exerciser.sv
// memory_exerciser: writes a seeded pattern to a word range, reads it back and counts mismatches
// ports: clk, reset (async active-low), start/seed request a pass, bus drives the memory responder,
//        busy/done/pass report status, err_count/first_err_addr report mismatches
module memory_exerciser
  import memory_exerciser_pkg::*;
#(
  parameter int base_addr  = 0,
  parameter int addr_size  = 16,
  parameter int word_size  = 16,
  parameter int word_count = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [word_size-1:0] seed,
  memory_exerciser_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [addr_size-1:0] err_count,
  output logic [addr_size-1:0] first_err_addr
);
  localparam logic [addr_size-1:0] first_addr = addr_size'(base_addr);
  localparam logic [addr_size-1:0] last_idx = addr_size'(word_count - 1);
  function automatic logic [word_size-1:0] pattern(input logic [word_size-1:0] s, input logic [addr_size-1:0] i);
    return (s + word_size'(i)) ^ {word_size{i[0]}};
  endfunction
  state_t               r_state;
  logic [addr_size-1:0] r_idx, r_addr, r_err, r_first, r_cmp_addr;
  logic [word_size-1:0] r_seed, r_data, r_exp;
  logic                 r_we, r_busy, r_done, r_pass, r_cmp;
  logic                 w_last, w_mis;
  logic [addr_size-1:0] w_next;
  assign w_last = r_idx == last_idx;
  assign w_next = r_idx + 1'b1;
  // r_cmp/r_exp trail the read address by one cycle, lining up with the responder's data
  assign w_mis = r_cmp && (bus.data_in != r_exp);
  assign bus.addr = r_addr;
  assign bus.data_out = r_data;
  assign bus.write_en = r_we;
  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;
  assign err_count = r_err;
  assign first_err_addr = r_first;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_seed <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err <= '0;
      r_first <= '0;
      r_cmp <= 1'b0;
      r_exp <= '0;
      r_cmp_addr <= '0;
    end else begin
      r_cmp <= r_state == READ;
      r_exp <= pattern(r_seed, r_idx);
      r_cmp_addr <= r_addr;
      if (w_mis && r_err != '1) r_err <= r_err + 1'b1;
      if (w_mis && r_err == '0) r_first <= r_cmp_addr;
      case (r_state)
        IDLE, DONE: begin
          // the first DONE cycle retires the last compare; status is published one edge later
          if (r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= r_err == '0;
          end else if (start) begin
            r_state <= WRITE;
            r_seed <= seed;
            r_idx <= '0;
            r_addr <= first_addr;
            r_data <= seed;
            r_we <= 1'b1;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err <= '0;
            r_first <= '0;
          end
        end
        WRITE: begin
          r_state <= w_last ? READ : WRITE;
          r_idx <= w_last ? '0 : w_next;
          r_we <= !w_last;
          r_addr <= w_last ? first_addr : first_addr + w_next;
          r_data <= w_last ? '0 : pattern(r_seed, w_next);
        end
        READ: begin
          r_state <= w_last ? DRAIN : READ;
          r_idx <= w_last ? '0 : w_next;
          r_addr <= w_last ? '0 : first_addr + w_next;
        end
        DRAIN: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_exerciser.sv
// tb_memory_exerciser: table-driven and randomized checks of memory_exerciser against a RAM responder
module tb_memory_exerciser;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [15:0] seed_a = '0;
  logic [15:0] seed_b = '0;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, first_a, err_b, first_b;
  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  typedef struct {
    logic [15:0] seed;
    int          mode;
    int          exp_err;
    logic [15:0] exp_first;
    logic        exp_pass;
  } vec_t;
  vec_t vecs [6];
  memory_exerciser_if #(.addr_size(16), .word_size(16)) bus_a();
  memory_exerciser_if #(.addr_size(16), .word_size(16)) bus_b();
  memory_exerciser #(.base_addr(8), .addr_size(16), .word_size(16), .word_count(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .seed(seed_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(first_a)
  );
  memory_exerciser #(.base_addr(3), .addr_size(16), .word_size(16), .word_count(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .seed(seed_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(first_b)
  );
  always #5 clk = ~clk;
  // RAM responders with a registered read; mode 1 corrupts address 10, mode 2 reads all zeros
  always @(posedge clk) begin
    if (bus_a.write_en) mem_a[bus_a.addr[7:0]] <= bus_a.data_out;
    bus_a.data_in <= mode == 2 ? 16'h0 : (mode == 1 && bus_a.addr == 16'd10) ? ~mem_a[bus_a.addr[7:0]] : mem_a[bus_a.addr[7:0]];
  end
  always @(posedge clk) begin
    if (bus_b.write_en) mem_b[bus_b.addr[7:0]] <= bus_b.data_out;
    bus_b.data_in <= mem_b[bus_b.addr[7:0]];
  end
  function automatic logic [15:0] pat(input logic [15:0] s, input int i);
    return (s + 16'(i)) ^ ((i % 2) != 0 ? 16'hFFFF : 16'h0000);
  endfunction
  function automatic void model(input logic [15:0] s, input int m, output int errs, output logic [15:0] first);
    errs = 0;
    first = '0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] p, rd;
      p = pat(s, i);
      rd = m == 2 ? 16'h0 : (m == 1 && i == 2) ? ~p : p;
      if (rd != p) begin
        if (errs == 0) first = 16'(8 + i);
        errs++;
      end
    end
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_a(input logic [15:0] s, input bit inject, input int e_err, input logic [15:0] e_first, input logic e_pass);
    int done_k, wn;
    bit busy_ok;
    int wk [8];
    logic [15:0] wa [8];
    logic [15:0] wd [8];
    @(negedge clk);
    seed_a = s;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    seed_a = ~s;
    chk("accept_busy", 32'(busy_a), 1);
    chk("accept_clear", 32'(done_a) + 32'(pass_a) + 32'(err_a) + 32'(first_a), 0);
    done_k = -1;
    wn = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (inject) begin
        start_a = k == 5;
        seed_a = 16'hAAAA;
      end
      if (bus_a.write_en && wn < 8) begin
        wk[wn] = k;
        wa[wn] = bus_a.addr;
        wd[wn] = bus_a.data_out;
        wn++;
      end
      if (done_a) done_k = k;
      else if (!busy_a) busy_ok = 1'b0;
    end
    start_a = 1'b0;
    chk("done_cycle", done_k, 10);
    chk("busy_held", 32'(busy_ok), 1);
    chk("busy_fall", 32'(busy_a), 0);
    chk("pass", 32'(pass_a), 32'(e_pass));
    chk("err_count", 32'(err_a), e_err);
    chk("first_err_addr", 32'(first_a), 32'(e_first));
    chk("write_count", wn, 4);
    for (int i = 0; i < 4 && i < wn; i++) begin
      chk("wr_cycle", wk[i], i);
      chk("wr_addr", 32'(wa[i]), 8 + i);
      chk("wr_data", 32'(wd[i]), 32'(pat(s, i)));
    end
  endtask
  initial begin
    int done_k, wn, e;
    logic [15:0] f;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {busy_a, done_a, pass_a, bus_a.write_en}, 0);
    chk("rst_bus", {bus_a.addr, bus_a.data_out}, 0);
    chk("rst_cnt", {err_a, first_a}, 0);
    @(negedge clk) reset = 1'b1;
    vecs[0] = '{16'h1234, 0, 0, 16'd0, 1'b1};
    vecs[1] = '{16'h1234, 1, 1, 16'd10, 1'b0};
    vecs[2] = '{16'h0000, 2, 3, 16'd9, 1'b0};
    for (int i = 3; i < 6; i++) begin
      vecs[i].seed = 16'($urandom);
      vecs[i].mode = int'($urandom_range(0, 2));
      model(vecs[i].seed, vecs[i].mode, e, f);
      vecs[i].exp_err = e;
      vecs[i].exp_first = f;
      vecs[i].exp_pass = e == 0;
    end
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      run_a(vecs[i].seed, 1'b0, vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_pass);
    end
    mode = 0;
    run_a(16'hBEEF, 1'b1, 0, 16'd0, 1'b1);
    @(negedge clk);
    seed_a = 16'h4242;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(bus_a.write_en), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctl", {busy_a, done_a, pass_a, bus_a.write_en}, 0);
    chk("mid_rst_bus", {bus_a.addr, bus_a.data_out}, 0);
    chk("mid_rst_cnt", {err_a, first_a}, 0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_rst", {busy_a, done_a, bus_a.write_en}, 0);
    chk("idle_addr", 32'(bus_a.addr), 0);
    @(negedge clk);
    seed_b = 16'hFFFF;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    seed_b = 16'h0;
    chk("b_write_en", 32'(bus_b.write_en), 1);
    chk("b_addr", 32'(bus_b.addr), 3);
    chk("b_data", 32'(bus_b.data_out), 32'h0000FFFF);
    done_k = -1;
    wn = 0;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus_b.write_en) wn++;
      if (done_b) done_k = k;
    end
    chk("b_done_cycle", done_k, 4);
    chk("b_write_count", wn, 1);
    chk("b_pass", 32'(pass_b), 1);
    chk("b_err", {err_b, first_b}, 0);
    mode = 0;
    seed_a = 16'($urandom);
    f = seed_a;
    model(f, 0, e, f);
    run_a(seed_a, 1'b0, e, f, e == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_exerciser.md
MEMORY_EXERCISER -- requirements
Module: memory_exerciser

Interface
REQ-001 SHALL have parameter base_addr, default 0: first word address exercised.
REQ-002 SHALL have parameter addr_size, default 16: bus address width in bits.
REQ-003 SHALL have parameter word_size, default 16: bus data width in bits.
REQ-004 SHALL have parameter word_count, default 2: number of consecutive words exercised, legal range 1..(2^addr_size - base_addr).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request to run one exercise pass.
REQ-008 SHALL have port seed, input, word_size bits: pattern seed, captured on an accepted start.
REQ-009 SHALL have port addr, output, addr_size bits: bus address to the memory responder.
REQ-010 SHALL have port data_out, output, word_size bits: write data to the memory responder.
REQ-011 SHALL have port data_in, input, word_size bits: read data from the responder, valid one cycle after addr is presented.
REQ-012 SHALL have port write_en, output, 1 bit: bus write strobe.
REQ-013 SHALL have port busy, output, 1 bit: high while a pass is running.
REQ-014 SHALL have port done, output, 1 bit: high once a pass completes, held until the next accepted start.
REQ-015 SHALL have port pass, output, 1 bit: high with done when the pass had zero mismatches.
REQ-016 SHALL have port err_count, output, addr_size bits: number of mismatching words.
REQ-017 SHALL have port first_err_addr, output, addr_size bits: bus address of the first mismatch; 0 if there was none.

Function
REQ-018 SHALL define pattern(i) = (seed_captured + i) XOR {word_size{i[0]}}, truncated to word_size bits, for i in 0..word_count-1.
REQ-019 SHALL implement the FSM IDLE -> WRITE -> READ -> DRAIN -> DONE; DONE -> WRITE on start; all other transitions automatic.
REQ-020 SHALL accept start only in IDLE or DONE; on acceptance: capture seed, clear err_count, first_err_addr, done and pass, and set busy.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL drive all bus outputs from registers.
REQ-023 WRITE: SHALL hold write_en=1 for exactly word_count cycles, starting the cycle after start is accepted; in cycle i, addr=base_addr+i and data_out=pattern(i).
REQ-024 READ: SHALL drive word_count cycles with write_en=0 and addr=base_addr+i, i ascending.
REQ-025 SHALL compare data_in in the cycle after each read address against the delayed pattern(i); DRAIN supplies the final compare slot.
REQ-026 SHALL increment err_count by 1 on each mismatch, saturating at all-ones.
REQ-027 SHALL latch first_err_addr on the first mismatch only.
REQ-028 SHALL assert done, and pass = (err_count==0), exactly 2*word_count+2 cycles after the start-acceptance edge; busy SHALL fall in the same cycle.
REQ-029 SHALL hold addr=0, data_out=0 and write_en=0 in IDLE, DRAIN and DONE.
REQ-030 SHALL handle word_count=1 with one write cycle, one read cycle and one drain cycle.
REQ-031 SHALL use internal index counters of width addr_size, with no wrap within a pass.

Reset
REQ-032 While reset=0 (asynchronous), SHALL force IDLE and set every output to 0: addr, data_out, write_en, busy, done, pass, err_count, first_err_addr.
REQ-033 Reset mid-pass SHALL drop write_en immediately and abandon the pass; after release, no pass runs until a new start.

Structure
REQ-034 SHALL place the FSM state encodings (5 states, 3 bits) in a shared package/include used by memory-bus initiators.
REQ-035 SHALL contain no sub-module; pattern generation and compare are inline.

Verification
REQ-036 Bench SHALL use a RAM responder model with 1-cycle registered read, word_count=4, base_addr=8, seed=16'h1234, start pulsed once -> writes to 8..11 of 1234, EDCA, 1236, EDC8; done and pass high 10 cycles after the start edge; err_count=0.
REQ-037 Same setup with the model corrupting address 10 on readback -> done with pass=0, err_count=1, first_err_addr=10.
REQ-038 Model returns all-zeros for every read, seed=0 -> err_count=3 (i=0 matches), first_err_addr=9.
REQ-039 Assert start again during READ -> ignored, completion timing unchanged; start in DONE -> new pass, with done cleared the next cycle.
REQ-040 Drive reset low mid-WRITE -> write_en and all outputs 0 the same cycle; after release, stays IDLE until start.
REQ-041 word_count=1, seed=16'hFFFF -> single write of FFFF at base_addr; done 4 cycles after the start edge with pass=1.
